serial_word_loader: RTL and testbench

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

---
 rtl/serial_word_loader_pkg.sv | 57 +++++
 rtl/serial_word_loader_bit_counter.sv | 45 ++++
 rtl/serial_word_loader.sv | 120 ++++++++++++
 tb/tb_serial_word_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for serial_word_loader: FSM state encoding, default word width
// and helpers that build the registered output bundle for each state.
package serial_word_loader_pkg;

    localparam int SER_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2
    } ser_state_e;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic ser_valid;
        logic ser_last;
        logic ser_bit;
        logic ser_clr;
    } ser_out_t;

    // Reset holds the downstream stage cleared and refuses new words
    function automatic ser_out_t outs_reset();
        ser_out_t o;
        o         = '0;
        o.ser_clr = 1'b1;
        return o;
    endfunction

    function automatic ser_out_t outs_idle();
        ser_out_t o;
        o          = '0;
        o.in_ready = 1'b1;
        return o;
    endfunction

    function automatic ser_out_t outs_clear();
        ser_out_t o;
        o         = '0;
        o.busy    = 1'b1;
        o.ser_clr = 1'b1;
        return o;
    endfunction

    function automatic ser_out_t outs_shift(input logic bit_v, input logic last_v,
                                            input logic ready_v);
        ser_out_t o;
        o           = '0;
        o.busy      = 1'b1;
        o.ser_valid = 1'b1;
        o.ser_bit   = bit_v;
        o.ser_last  = last_v;
        o.in_ready  = ready_v;
        return o;
    endfunction

endpackage

// File: rtl/serial_word_loader_bit_counter.sv
// Clearable, enabled bit counter with a registered terminal-count flag and a
// look-ahead flag telling whether the value about to be loaded is terminal.
module bit_counter #(
    parameter int            CW  = 3,
    parameter logic [CW-1:0] MAX = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o,
    output logic tc_next_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          tc_q;

    // Next count: clear wins over enable, otherwise hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count and terminal-count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= (MAX == {CW{1'b0}});
        end else begin
            count_q <= count_d;
            tc_q    <= (count_d == MAX);
        end
    end

    assign tc_o      = tc_q;
    assign tc_next_o = (count_d == MAX);

endmodule

// File: rtl/serial_word_loader.sv
// Parallel-to-serial word loader (LSB first) with a one-cycle downstream clear per word.
// Define SERIAL_LOADER_B2B_EN to accept the next word during the last bit of the current one.
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_clr,
    output logic             ser_last,
    output logic             busy
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
`ifdef SERIAL_LOADER_B2B_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    ser_state_e       state_q;
    logic [WIDTH-1:0] shift_q;
    ser_out_t         out_q;
    logic             accept_s;
    logic             cnt_clr_s;
    logic             cnt_en_s;
    logic             tc_s;
    logic             tc_next_s;

    // in_ready comes from a register, so accepting never forms an input-to-output path
    assign accept_s = in_valid & out_q.in_ready;

    // Counter advances only between bits of a word and is parked at zero elsewhere
    always_comb begin
        cnt_clr_s = 1'b1;
        cnt_en_s  = 1'b0;
        if ((state_q == SHIFT) && !tc_s) begin
            cnt_clr_s = 1'b0;
            cnt_en_s  = 1'b1;
        end else begin
            cnt_clr_s = 1'b1;
            cnt_en_s  = 1'b0;
        end
    end

    bit_counter #(
        .CW  (CW),
        .MAX (CNT_MAX)
    ) u_bit_counter (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (cnt_clr_s),
        .en_i      (cnt_en_s),
        .tc_o      (tc_s),
        .tc_next_o (tc_next_s)
    );

    // Loader FSM; outputs are registered alongside the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            out_q   <= outs_reset();
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q <= CLEAR;
                        shift_q <= in_data;
                        out_q   <= outs_clear();
                    end else begin
                        state_q <= IDLE;
                        out_q   <= outs_idle();
                    end
                end
                CLEAR: begin
                    state_q <= SHIFT;
                    out_q   <= outs_shift(shift_q[0], tc_next_s, B2B & tc_next_s);
                end
                SHIFT: begin
                    if (tc_s) begin
                        if (B2B && accept_s) begin
                            state_q <= CLEAR;
                            shift_q <= in_data;
                            out_q   <= outs_clear();
                        end else begin
                            state_q <= IDLE;
                            shift_q <= '0;
                            out_q   <= outs_idle();
                        end
                    end else begin
                        state_q <= SHIFT;
                        shift_q <= {1'b0, shift_q[WIDTH-1:1]};
                        out_q   <= outs_shift(shift_q[1], tc_next_s, B2B & tc_next_s);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    shift_q <= '0;
                    out_q   <= outs_idle();
                end
            endcase
        end
    end

    assign in_ready  = out_q.in_ready;
    assign busy      = out_q.busy;
    assign ser_valid = out_q.ser_valid;
    assign ser_last  = out_q.ser_last;
    assign ser_bit   = out_q.ser_bit;
    assign ser_clr   = out_q.ser_clr;

endmodule

// File: tb/tb_serial_word_loader.sv
// Bench for serial_word_loader: WIDTH=8 and WIDTH=2 instances run in lockstep, each checked every
// cycle against a prediction built from the latency rules, with a downstream negator on the 8-bit stream.
module tb_serial_word_loader;

`ifdef SERIAL_LOADER_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif
    localparam int PERIOD8 = B2B ? 9 : 10;

    typedef struct packed {
        logic rdy; logic busy; logic val; logic last; logic bitv; logic clr;
    } obs_t;
    typedef struct {
        bit known; bit rst_prev; bit have; int t; int w; logic [31:0] word;
    } mdl_t;
    typedef struct { logic [7:0] raw; logic [7:0] neg; int len; } done_t;
    typedef struct { logic [7:0] data; logic [7:0] exp_neg; } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v8, v2;
    logic [7:0] d8;
    logic [1:0] d2;
    logic       rdy8, bit8, val8, clr8, last8, busy8;
    logic       rdy2, bit2, val2, clr2, last2, busy2;

    always #5 clk = ~clk;

    serial_word_loader #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
        .ser_bit(bit8), .ser_valid(val8), .ser_clr(clr8), .ser_last(last8), .busy(busy8)
    );

    serial_word_loader #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(rst), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
        .ser_bit(bit2), .ser_valid(val2), .ser_clr(clr2), .ser_last(last2), .busy(busy2)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    mdl_t        m8, m2;
    obs_t        o8, o2;
    bit          acc8;
    logic [7:0]  acc_q[$];
    done_t       done_q[$];
    logic [7:0]  ds_raw, ds_neg;
    int          ds_k;
    bit          ds_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected outputs in cycle n: word accepted at edge t -> clear at t+1, bit k at t+2+k
    function automatic obs_t predict(input mdl_t m, input int n);
        obs_t o;
        int   k;
        o = '0;
        if (m.rst_prev) begin
            o.clr = 1'b1;
        end else if (m.have && n == m.t + 1) begin
            o.busy = 1'b1; o.clr = 1'b1;
        end else if (m.have && n >= m.t + 2 && n <= m.t + 1 + m.w) begin
            k      = n - m.t - 2;
            o.busy = 1'b1; o.val = 1'b1;
            o.bitv = m.word[k[4:0]];
            o.last = (k == m.w - 1);
            o.rdy  = B2B && o.last;
        end else begin
            o.rdy = 1'b1;
        end
        return o;
    endfunction

    task automatic advance(inout mdl_t m, input bit r, input bit v, input logic [31:0] d,
                           input obs_t p, input int n, output bit acc, output bit drop);
        acc = 1'b0; drop = 1'b0;
        if (r) begin
            drop = m.have && (n < m.t + 1 + m.w);
            m.have = 1'b0; m.rst_prev = 1'b1; m.known = 1'b1;
        end else begin
            m.rst_prev = 1'b0;
            if (m.known && v && p.rdy) begin
                m.have = 1'b1; m.t = n; m.word = d; acc = 1'b1;
            end
        end
    endtask

    // Downstream bit-serial two's-complement negator fed by the 8-bit loader
    task automatic downstream();
        if (o8.clr === 1'b1) begin
            ds_raw = '0; ds_neg = '0; ds_k = 0; ds_seen = 1'b0;
        end else if (o8.val === 1'b1) begin
            if (ds_k < 8) begin
                ds_raw[ds_k[2:0]] = o8.bitv;
                ds_neg[ds_k[2:0]] = ds_seen ? ~o8.bitv : o8.bitv;
            end
            if (o8.bitv === 1'b1) ds_seen = 1'b1;
            ds_k++;
            if (o8.last === 1'b1) begin
                done_q.push_back('{ds_raw, ds_neg, ds_k});
                ds_raw = '0; ds_neg = '0; ds_k = 0; ds_seen = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit va, input logic [7:0] da,
                         input bit vb, input logic [1:0] db);
        obs_t p8, p2;
        bit   a, dr;
        rst = r; v8 = va; d8 = da; v2 = vb; d2 = db;
        @(negedge clk);
        o8   = {rdy8, busy8, val8, last8, bit8, clr8};
        o2   = {rdy2, busy2, val2, last2, bit2, clr2};
        acc8 = va && (o8.rdy === 1'b1) && !r;
        p8   = predict(m8, cyc);
        p2   = predict(m2, cyc);
        if (m8.known) chk("w8_outputs", 32'(o8), 32'(p8));
        if (m2.known) chk("w2_outputs", 32'(o2), 32'(p2));
        downstream();
        advance(m8, r, va, 32'(da), p8, cyc, a, dr);
        if (a) acc_q.push_back(da);
        if (dr && acc_q.size() > 0) void'(acc_q.pop_back());
        advance(m2, r, vb, 32'(db), p2, cyc, a, dr);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    endtask

    task automatic send8(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            cycle(1'b0, 1'b1, d, 1'b0, 2'b00);
            ok = acc8;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        done_t      d;
        logic [7:0] e;
        while (done_q.size() > 0) begin
            d = done_q.pop_front();
            chk("word_expected", 32'(acc_q.size() > 0), 32'd1);
            if (acc_q.size() > 0) begin
                e = acc_q.pop_front();
                chk("word_bits", 32'(d.raw), 32'(e));
                chk("word_neg", 32'(d.neg), 32'(8'(~e + 8'd1)));
                chk("word_len", 32'(d.len), 32'd8);
            end
        end
        chk("lost_words", 32'(acc_q.size()), 32'd0);
        acc_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[7];
        done_t      d;
        logic [7:0] bits_exp;
        int         acc_cycles[$];
        bit         r, va, vb;

        tbl[0] = '{8'h06, 8'hFA}; tbl[1] = '{8'h80, 8'h80}; tbl[2] = '{8'h01, 8'hFF};
        tbl[3] = '{8'hFF, 8'h01}; tbl[4] = '{8'h00, 8'h00}; tbl[5] = '{8'h7F, 8'h81};
        tbl[6] = '{8'hA5, 8'h5B};

        m8 = '{known: 1'b0, rst_prev: 1'b0, have: 1'b0, t: 0, w: 8, word: 32'd0};
        m2 = '{known: 1'b0, rst_prev: 1'b0, have: 1'b0, t: 0, w: 2, word: 32'd0};
        rst = 1'b1; v8 = 1'b0; d8 = 8'h00; v2 = 1'b0; d2 = 2'b00;
        ds_raw = '0; ds_neg = '0; ds_k = 0; ds_seen = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, with in_valid asserted to show reset priority
        cycle(1'b1, 1'b1, 8'h55, 1'b1, 2'b01);
        cycle(1'b1, 1'b1, 8'h55, 1'b1, 2'b01);
        chk("reset_outs", 32'(o8), 32'(6'b000001));
        idle(2);
        chk("idle_outs", 32'(o8), 32'(6'b100000));
        acc_q.delete(); done_q.delete();

        // Latency of 0x06: clear then bits 0,1,1,0,0,0,0,0 with last on the eighth
        send8(8'h06);
        idle(1);
        chk("lat_clear", 32'({o8.clr, o8.val, o8.rdy}), 32'(3'b100));
        bits_exp = 8'b0000_0110;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            chk("lat_bit", 32'({o8.val, o8.bitv, o8.last}), 32'({1'b1, bits_exp[k[2:0]], k == 7}));
        end
        idle(1);
        chk("lat_idle", 32'({o8.val, o8.rdy, o8.busy}), 32'(3'b010));
        drain();

        // Table of words against known serial contents and negated results
        for (int i = 0; i < 7; i++) begin
            send8(tbl[i].data);
            idle(10);
            chk("tbl_done_count", 32'(done_q.size()), 32'd1);
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                chk("tbl_bits", 32'(d.raw), 32'(tbl[i].data));
                chk("tbl_neg", 32'(d.neg), 32'(tbl[i].exp_neg));
            end
            done_q.delete();
            acc_q.delete();
        end

        // Continuous offers: one accept per word and a fixed word period
        for (int i = 0; i < 45; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 2'b00);
            if (acc8) acc_cycles.push_back(cyc - 1);
        end
        idle(12);
        chk("burst_accepts", 32'(acc_cycles.size() >= 4), 32'd1);
        for (int i = 1; i < acc_cycles.size(); i++)
            chk("burst_period", 32'(acc_cycles[i] - acc_cycles[i-1]), 32'(PERIOD8));
        drain();

        // Reset during the fourth bit with in_valid high
        send8(8'hC3);
        idle(4);
        chk("rst_mid_bit3", 32'({o8.val, o8.bitv}), 32'(2'b10));
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 2'b00);
        cycle(1'b0, 1'b1, 8'h3C, 1'b0, 2'b00);
        chk("rst_mid_after", 32'({o8.clr, o8.val, o8.rdy, o8.busy}), 32'(4'b1000));
        idle(1);
        chk("rst_mid_idle", 32'({o8.clr, o8.val, o8.rdy}), 32'(3'b001));
        send8(8'h5A);
        idle(10);
        drain();

        // WIDTH=2 word 0x3: clear, bit 1, bit 1 with last, then idle
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 2'b11);
        chk("w2_accept", 32'(o2.rdy), 32'd1);
        idle(1);
        chk("w2_clear", 32'({o2.clr, o2.val, o2.busy}), 32'(3'b101));
        idle(1);
        chk("w2_bit0", 32'({o2.val, o2.bitv, o2.last}), 32'(3'b110));
        idle(1);
        chk("w2_bit1", 32'({o2.val, o2.bitv, o2.last}), 32'(3'b111));
        idle(1);
        chk("w2_idle", 32'({o2.val, o2.busy, o2.rdy}), 32'(3'b001));

        // Random traffic with occasional resets on both instances
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(49, 0) == 0);
            va = 1'($urandom);
            vb = 1'($urandom);
            cycle(r, va, 8'($urandom), vb, 2'($urandom));
        end
        idle(12);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
